// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 serial receiver: frame shape, synchronizer
// depth and the receive state encoding.
package uart_rx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } rx_state_t;

  function automatic logic in_frame(input rx_state_t s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Bit-timing down-counter: load_half aims at mid start bit, load_full at the
// next bit centre; tick is high while the count sits at zero.
module rx_baud_tick #(
  parameter int BAUD = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int CW   = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam int HALF = BAUD / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

  logic [CW-1:0] cnt;

  // Holds at zero between frames rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn)                cnt <= '0;
    else if (load_half)       cnt <= HALF_M1;
    else if (load_full)       cnt <= FULL_M1;
    else if (cnt != '0)       cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous receiver: synchronizes rx, centres on each bit using
// rx_baud_tick, and emits one-cycle rcv / ferr strobes per frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int ACW = $clog2(SYNC_DEPTH + 1);
  localparam int BIW = $clog2(DATA_BITS);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  rx_s;
  logic [ACW-1:0]        arm_cnt;
  logic                  arm_ok;

  rx_state_t             state, state_n;
  logic [BIW-1:0]        bit_idx;
  logic [DATA_BITS-1:0]  shreg;

  logic                  tick;
  logic                  load_half, load_full;
  logic                  sample_bit, set_rcv, set_ferr, clr_idx;

  always_ff @(posedge clk) begin
    if (!rstn) sync <= '1;
    else       sync <= {sync[SYNC_DEPTH-2:0], rx};
  end

  assign rx_s = sync[SYNC_DEPTH-1];

  // rx_s only reflects the real line once the synchronizer has refilled
  // after reset; until then ARM must not trust its reset value of 1.
  always_ff @(posedge clk) begin
    if (!rstn)        arm_cnt <= '0;
    else if (!arm_ok) arm_cnt <= arm_cnt + 1'b1;
  end

  assign arm_ok = (arm_cnt == ACW'(SYNC_DEPTH));

  rx_baud_tick #(
    .BAUD (BAUD)
  ) u_tick (
    .clk       (clk),
    .rstn      (rstn),
    .load_half (load_half),
    .load_full (load_full),
    .tick      (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_ARM;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    set_rcv    = 1'b0;
    set_ferr   = 1'b0;
    clr_idx    = 1'b0;
    case (state)
      ST_ARM: begin
        if (arm_ok && rx_s) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (!rx_s) begin
          state_n   = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_DATA;
            load_full = 1'b1;
            clr_idx   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          load_full  = 1'b1;
          if (bit_idx == BIW'(DATA_BITS - 1)) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s) begin
            set_rcv = 1'b1;
            state_n = ST_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_n  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)           bit_idx <= '0;
    else if (clr_idx)    bit_idx <= '0;
    else if (sample_bit) bit_idx <= bit_idx + 1'b1;
  end

  // LSB arrives first, so shift in at the top.
  always_ff @(posedge clk) begin
    if (sample_bit) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data <= '0;
      rcv  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      rcv  <= set_rcv;
      ferr <= set_ferr;
      if (set_rcv) data <= shreg;
    end
  end

  assign busy = in_frame(state);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD=16: frames are generated bit by bit,
// expected strobes (kind, byte, cycle) queued, and a negedge monitor checks them.
module tb_uart_rx;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  // Drive edge -> rcv/ferr visible: 1 cycle to the drive edge, 2 synchronizer
  // stages, HALF to mid start bit, 9 bit periods to mid stop bit.
  localparam int LAT  = 3 + HALF + 9 * BAUD;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] byte_v;
    int         when;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_good = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) next_cyc();
  endtask

  // One 8N1 frame; the expected outcome is pushed before the first bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    exp_t e;
    e.is_err = !stop_ok;
    e.byte_v = b;
    e.when   = cyc + LAT;
    q.push_back(e);
    rx = 1'b0;
    repeat (BAUD) next_cyc();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) next_cyc();
    end
    rx = stop_ok;
    repeat (BAUD) next_cyc();
    if (!stop_ok) repeat (extra_low) next_cyc();
    rx = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the queue.
  initial begin
    exp_t e;
    bit   prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_good   = 8'h00;
        prev_strobe = 1'b0;
      end else begin
        if (rcv && ferr) chk("rcv_ferr_exclusive", 32'd1, 32'd0);
        if (rcv || ferr) begin
          if (prev_strobe) chk("strobe_one_cycle", 32'd1, 32'd0);
          if (q.size() == 0) begin
            chk("unexpected_strobe", {30'd0, ferr, rcv}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("strobe_kind_ferr", {31'd0, ferr}, {31'd0, e.is_err});
            chk("strobe_cycle", cyc, e.when);
            if (!e.is_err) begin
              chk("rcv_data", {24'd0, data}, {24'd0, e.byte_v});
              last_good = e.byte_v;
            end else begin
              chk("ferr_data_hold", {24'd0, data}, {24'd0, last_good});
            end
          end
        end
        prev_strobe = rcv | ferr;
      end
    end
  end

  initial begin
    logic [7:0] hello[13];
    int         nb;
    int         w;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) next_cyc();
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_rcv",  {31'd0, rcv},  32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    idle(10);

    // Single 'H' with exact timing, then the greeting back-to-back.
    send_frame(8'h48, 1'b1, 0);
    idle(5);
    foreach (hello[i]) send_frame(hello[i], 1'b1, 0);
    idle(10);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Short glitch: rejected at mid start bit.
    rx = 1'b0;
    repeat (5) next_cyc();
    rx = 1'b1;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) nb++;
      next_cyc();
    end
    chk("glitch_busy_in_range", {31'd0, (nb >= 1 && nb <= HALF)}, 32'd1);
    chk("glitch_busy_released", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 1'b1, 0);
    idle(5);

    // Framing error with line held low, then a clean copy.
    send_frame(8'h3C, 1'b0, 40);
    idle(4);
    send_frame(8'h3C, 1'b1, 0);
    idle(5);

    // Reset during data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (BAUD) next_cyc();
    rx = 1'b1;
    repeat (4 * BAUD + HALF) next_cyc();
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    next_cyc();
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_rcv",  {31'd0, rcv},  32'd0);
    chk("midrst_ferr", {31'd0, ferr}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    next_cyc();
    rstn = 1'b1;
    idle(6);
    send_frame(8'h81, 1'b1, 0);
    idle(5);

    // Line held low through reset release.
    rstn = 1'b0;
    rx   = 1'b0;
    repeat (4) next_cyc();
    rstn = 1'b1;
    repeat (100) next_cyc();
    chk("held_low_busy", {31'd0, busy}, 32'd0);
    idle(20);
    send_frame(8'h55, 1'b1, 0);
    idle(5);

    // Randomized frames, gaps and framing errors.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0, $urandom_range(0, 40));
        idle($urandom_range(2, 6));
      end else begin
        send_frame(b, 1'b1, 0);
        idle($urandom_range(0, 3));
      end
    end

    w = 0;
    while (q.size() != 0 && w < 2 * LAT) begin
      next_cyc();
      w++;
    end
    chk("queue_drained", q.size(), 32'd0);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
